dadda_dot_accumulator: RTL and testbench

//  Sequential stage wrapped around the combinational 8x8 approximate Dadda multiplier.
//  - Upstream side: accepts operand pairs over a valid/ready handshake and registers them.
//    The registered pair drives the multiplier inputs.
//  - Downstream side: consumes the 16-bit product and accumulates LEN consecutive products

---
 rtl/dadda_mac_pkg.sv | 27 ++
 rtl/dot_beat_counter.sv | 52 +++++
 rtl/dadda_dot_accumulator.sv | 146 ++++++++++++++
 tb/tb_dadda_dot_accumulator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dadda_mac_pkg.sv
// Shared constants and helpers for the Dadda multiply-accumulate datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   OP_W   - operand width of the 8x8 multiplier
//   PROD_W - product width of the 8x8 multiplier
//   clog2  - ceiling log2, usable in constant (parameter) expressions
package dadda_mac_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  // ceil(log2(value)); clog2(1) == 0, clog2(0) == 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage : dadda_mac_pkg

// File: rtl/dot_beat_counter.sv
// Modulo-LEN beat counter with a flag marking the final beat of a vector.
// Latency: cnt/last are registered; inc takes effect on the next rising edge.
// Backpressure: none; the owner pulses inc only on an accepted beat.
//
// Ports:
//   clk  in  1      clock, rising edge
//   rst  in  1      asynchronous active-high reset (count clears to 0)
//   inc  in  1      advance the count by one, wrapping after LEN-1
//   cnt  out CNT_W  index of the next beat
//   last out 1      cnt == LEN-1
module dot_beat_counter
  import dadda_mac_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      // Explicit wrap so non-power-of-two LEN works.
      if (cnt_q == LAST_IDX) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == LAST_IDX);

endmodule : dot_beat_counter

// File: rtl/dadda_dot_accumulator.sv
// Registers operand pairs for the external 8x8 multiplier and sums LEN products into a dot product.
// Latency: last beat accepted at edge N -> out_valid after edge N+1; one beat per cycle when unstalled.
// Backpressure: only a held result blocks the next vector's last beat; earlier beats keep retiring.
//
// Ports:
//   clk        in  1      clock, rising edge
//   rst        in  1      asynchronous active-high reset
//   in_valid   in  1      operand pair valid
//   in_ready   out 1      stage can take an operand pair
//   in_a       in  8      multiplicand
//   in_b       in  8      multiplier
//   mul_a      out 8      registered operand to multiplier input a
//   mul_b      out 8      registered operand to multiplier input b
//   mul_y      in  16     multiplier product, combinational from mul_a/mul_b
//   out_valid  out 1      result valid, held until accepted
//   out_ready  in  1      consumer accepts result
//   out_result out ACC_W  dot-product result
//   beat_cnt   out CNT_W  index of the next beat to accept
module dadda_dot_accumulator
  import dadda_mac_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int ACC_W = 24,
  // Derived; not meant to be overridden.
  parameter int CNT_W = (clog2(LEN) < 1) ? 1 : clog2(LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_result,
  output logic [CNT_W-1:0]  beat_cnt
);

  // The accumulator must hold LEN full-scale products without wrapping.
  if (LEN < 1) begin : g_len_err
    $error("dadda_dot_accumulator: LEN must be >= 1");
  end
  if (ACC_W < PROD_W + clog2(LEN)) begin : g_width_err
    $error("dadda_dot_accumulator: ACC_W must be >= 16 + clog2(LEN)");
  end

  // Stage 1: operand register feeding the multiplier.
  logic [OP_W-1:0]  mul_a_q, mul_a_d;
  logic [OP_W-1:0]  mul_b_q, mul_b_d;
  logic             s1_v_q, s1_v_d;
  logic             s1_last_q, s1_last_d;

  // Stage 2: running sum and the presented result.
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_result_q, out_result_d;
  logic             out_valid_q, out_valid_d;

  logic             xfer;
  logic             stall;
  logic             retire;
  logic             cnt_last;
  logic [ACC_W-1:0] sum;

  dot_beat_counter #(
    .LEN   (LEN),
    .CNT_W (CNT_W)
  ) u_beat_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (xfer),
    .cnt  (beat_cnt),
    .last (cnt_last)
  );

  // A last beat cannot retire into a result slot the consumer still owns.
  assign stall    = s1_v_q && s1_last_q && out_valid_q && !out_ready;
  assign retire   = s1_v_q && !stall;
  assign in_ready = !s1_v_q || !stall;
  assign xfer     = in_valid && in_ready;

  // Product is taken as-is; approximate low bits are not corrected.
  assign sum = acc_q + ACC_W'(mul_y);

  always_comb begin
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    s1_v_d    = s1_v_q;
    s1_last_d = s1_last_q;
    if (xfer) begin
      mul_a_d   = in_a;
      mul_b_d   = in_b;
      s1_v_d    = 1'b1;
      s1_last_d = cnt_last;
    end else if (retire) begin
      s1_v_d    = 1'b0;
    end
  end

  always_comb begin
    acc_d        = acc_q;
    out_result_d = out_result_q;
    out_valid_d  = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    // A last beat retiring alongside a handshake overrides the clear above.
    if (retire) begin
      if (s1_last_q) begin
        out_result_d = sum;
        out_valid_d  = 1'b1;
        acc_d        = '0;
      end else begin
        acc_d        = sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      s1_v_q       <= 1'b0;
      s1_last_q    <= 1'b0;
      acc_q        <= '0;
      out_result_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      s1_v_q       <= s1_v_d;
      s1_last_q    <= s1_last_d;
      acc_q        <= acc_d;
      out_result_q <= out_result_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

endmodule : dadda_dot_accumulator

// File: tb/tb_dadda_dot_accumulator.sv
// Directed bench for dadda_dot_accumulator with LEN=4, ACC_W=24.
// Inputs are driven 1ns after the rising edge and outputs sampled there too.
// mul_y comes from an exact a*b stub, or from a truncating approximate model when use_approx=1.
module tb_dadda_dot_accumulator;

  localparam int LEN   = 4;
  localparam int ACC_W = 24;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic [15:0]      mul_y;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_result;
  logic [CNT_W-1:0] beat_cnt;

  logic use_approx = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Stand-in for the approximate multiplier: exact product with the low 3 bits dropped.
  function automatic logic [15:0] approx_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, a} * {8'd0, b};
    return p & 16'hFFF8;
  endfunction

  assign mul_y = use_approx ? approx_mul(mul_a, mul_b) : ({8'd0, mul_a} * {8'd0, mul_b});

  dadda_dot_accumulator #(
    .LEN   (LEN),
    .ACC_W (ACC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_y      (mul_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .beat_cnt   (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and hold it until accepted (bounded). Returns 1ns after the accepting edge.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until out_valid is high at a sample point.
  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset_state();
    rst = 1'b1;
    #3;
    n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL por_out_valid got=%0d exp=0", out_valid); end
    n_checks++; if (out_result !== '0)   begin n_fail++; $display("FAIL por_out_result got=%0d exp=0", out_result); end
    n_checks++; if (beat_cnt !== '0)     begin n_fail++; $display("FAIL por_beat_cnt got=%0d exp=0", beat_cnt); end
    n_checks++; if (mul_a !== 8'd0 || mul_b !== 8'd0) begin n_fail++; $display("FAIL por_mul_ab got=%0d,%0d exp=0,0", mul_a, mul_b); end
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL por_in_ready got=%0d exp=1", in_ready); end
  endtask

  task automatic test_single_vector();
    bit ok;
    logic [7:0] va [4] = '{8'd3, 8'd2, 8'd10, 8'd255};
    logic [7:0] vb [4] = '{8'd5, 8'd7, 8'd10, 8'd255};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(va[i], vb[i], ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL single_accept_%0d got=timeout exp=accepted", i); end
      if (i == 0) begin
        n_checks++; if (mul_a !== 8'd3 || mul_b !== 8'd5) begin n_fail++; $display("FAIL single_mul_regs got=%0d,%0d exp=3,5", mul_a, mul_b); end
      end
    end
    // Edge N just passed: result not yet visible.
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%0d exp=0", out_valid); end
    n_checks++; if (beat_cnt !== 2'd0)  begin n_fail++; $display("FAIL single_cnt_wrap got=%0d exp=0", beat_cnt); end
    tick();
    n_checks++; if (out_valid !== 1'b1)       begin n_fail++; $display("FAIL single_valid got=%0d exp=1", out_valid); end
    n_checks++; if (out_result !== 24'd65154) begin n_fail++; $display("FAIL single_result got=%0d exp=65154", out_result); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_pulse got=%0d exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    send_beat(8'd9, 8'd9, ok);
    send_beat(8'd9, 8'd9, ok);
    rst = 1'b1;
    #1;
    n_checks++; if (mul_a !== 8'd0 || mul_b !== 8'd0) begin n_fail++; $display("FAIL rst_mul_ab got=%0d,%0d exp=0,0", mul_a, mul_b); end
    n_checks++; if (out_result !== '0) begin n_fail++; $display("FAIL rst_out_result got=%0d exp=0", out_result); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%0d exp=0", out_valid); end
    n_checks++; if (beat_cnt !== '0) begin n_fail++; $display("FAIL rst_beat_cnt got=%0d exp=0", beat_cnt); end
    #1;
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%0d exp=1", in_ready); end
  endtask

  task automatic test_backpressure();
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(8'd1, 8'd1, ok);
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_result !== 24'd4) begin n_fail++; $display("FAIL bp_first got=%0d/%0d exp=1/4", out_valid, out_result); end
    for (int i = 0; i < 3; i++) begin
      send_beat(8'd1, 8'd1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_beat_%0d got=timeout exp=accepted", i); end
    end
    send_beat(8'd1, 8'd1, ok);
    // Last beat now sits in stage 1 behind the held result.
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_stall got=%0d exp=0", in_ready); end
    tick();
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold got=rdy%0d/vld%0d exp=rdy0/vld1", in_ready, out_valid); end
    n_checks++; if (out_result !== 24'd4) begin n_fail++; $display("FAIL bp_held_result got=%0d exp=4", out_result); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy got=%0d exp=1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_result !== 24'd4) begin n_fail++; $display("FAIL bp_second got=%0d/%0d exp=1/4", out_valid, out_result); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%0d exp=0", out_valid); end
  endtask

  task automatic test_bubbles();
    bit ok;
    logic [7:0] va [4] = '{8'd3, 8'd2, 8'd10, 8'd255};
    logic [7:0] vb [4] = '{8'd5, 8'd7, 8'd10, 8'd255};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (beat_cnt !== CNT_W'(i)) begin n_fail++; $display("FAIL bub_cnt_%0d got=%0d exp=%0d", i, beat_cnt, i); end
      send_beat(va[i], vb[i], ok);
      if (i < 3) tick();
    end
    n_checks++; if (beat_cnt !== 2'd0) begin n_fail++; $display("FAIL bub_cnt_wrap got=%0d exp=0", beat_cnt); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_result !== 24'd65154) begin n_fail++; $display("FAIL bub_result got=%0d/%0d exp=1/65154", out_valid, out_result); end
    tick();
  endtask

  task automatic test_reset_mid_vector();
    bit ok;
    send_beat(8'd255, 8'd255, ok);
    send_beat(8'd255, 8'd255, ok);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    n_checks++; if (beat_cnt !== 2'd0) begin n_fail++; $display("FAIL rmv_cnt got=%0d exp=0", beat_cnt); end
    for (int i = 0; i < 4; i++) send_beat(8'd1, 8'd2, ok);
    wait_result(ok);
    n_checks++; if (!ok || out_result !== 24'd8) begin n_fail++; $display("FAIL rmv_result got=%0d (valid=%0d) exp=8", out_result, ok); end
    tick();
  endtask

  task automatic test_real_mult();
    bit ok;
    logic [7:0] va [8] = '{8'd255, 8'd13, 8'd200, 8'd7, 8'd100, 8'd15, 8'd0, 8'd128};
    logic [7:0] vb [8] = '{8'd255, 8'd11, 8'd3, 8'd7, 8'd100, 8'd15, 8'd99, 8'd2};
    use_approx = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(va[i], vb[i], ok);
    n_checks++; if (beat_cnt !== 2'd0) begin n_fail++; $display("FAIL apx_cnt_wrap got=%0d exp=0", beat_cnt); end
    wait_result(ok);
    // 65024 + 136 + 600 + 48
    n_checks++; if (!ok || out_result !== 24'd65808) begin n_fail++; $display("FAIL apx_vec0 got=%0d (valid=%0d) exp=65808", out_result, ok); end
    tick();
    for (int i = 4; i < 8; i++) send_beat(va[i], vb[i], ok);
    wait_result(ok);
    // 10000 + 224 + 0 + 256
    n_checks++; if (!ok || out_result !== 24'd10480) begin n_fail++; $display("FAIL apx_vec1 got=%0d (valid=%0d) exp=10480", out_result, ok); end
    tick();
    use_approx = 1'b0;
  endtask

  initial begin
    test_reset_state();
    test_single_vector();
    test_reset_midstream();
    test_backpressure();
    test_bubbles();
    test_reset_mid_vector();
    test_real_mult();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dadda_dot_accumulator
